// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared lane count, judge state encoding and default timing constants
package ddr_pkg;

   localparam int LANES          = 8;
   localparam int DEF_WINDOW_CYC = 2500000;
   localparam int DEF_HOLD_CYC   = 5000000;
   localparam int DEF_HIT_POINTS = 10;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } judge_state_t;

endpackage

// File: rtl/note_lane_judge.sv
// rtl/note_lane_judge.sv - one lane: button sync/edge detect, hit-window FSM, judgment hold
module note_lane_judge
   import ddr_pkg::*;
#(
   parameter int WINDOW_CYC = DEF_WINDOW_CYC,
   parameter int HOLD_CYC   = DEF_HOLD_CYC,
   parameter int WIN_W      = 22,
   parameter int HOLD_W     = 23
) (
   input  logic clk,
   input  logic rst,
   input  logic note_arrive,
   input  logic button,
   output logic action,
   output logic success,
   output logic hit,
   output logic miss
);

   localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(WINDOW_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

   logic [2:0]        sync;
   logic              press;
   judge_state_t      state, state_next;
   logic [WIN_W-1:0]  win_cnt, cnt_next;
   logic [HOLD_W-1:0] hold_cnt;

   // sync[1] is the metastability-safe sample; sync[2] delays it for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[1:0], button};
         press <= sync[1] & ~sync[2];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         win_cnt <= '0;
      end else begin
         state   <= state_next;
         win_cnt <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = win_cnt;
      hit        = 1'b0;
      miss       = 1'b0;
      case (state)
         IDLE: begin
            if (note_arrive) begin
               if (press) begin
                  hit = 1'b1;
               end else begin
                  state_next = PENDING;
                  cnt_next   = WIN_LOAD;
               end
            end
         end
         PENDING: begin
            // a press always judges the old note; a new arrival always reopens the window
            if (press)
               hit = 1'b1;
            else if (note_arrive || win_cnt == '0)
               miss = 1'b1;
            if (note_arrive)
               cnt_next = WIN_LOAD;
            else if (press || win_cnt == '0)
               state_next = IDLE;
            else
               cnt_next = win_cnt - 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         action   <= 1'b0;
         success  <= 1'b0;
         hold_cnt <= '0;
      end else if (hit || miss) begin
         action   <= 1'b1;
         success  <= hit;
         hold_cnt <= HOLD_LOAD;
      end else if (action) begin
         if (hold_cnt == '0) begin
            action  <= 1'b0;
            success <= 1'b0;
         end else begin
            hold_cnt <= hold_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/note_judge.sv
// rtl/note_judge.sv - per-lane judges plus saturating score and combo accumulation
module note_judge #(
   parameter int LANES      = ddr_pkg::LANES,
   parameter int WINDOW_CYC = ddr_pkg::DEF_WINDOW_CYC,
   parameter int HOLD_CYC   = ddr_pkg::DEF_HOLD_CYC,
   parameter int HIT_POINTS = ddr_pkg::DEF_HIT_POINTS,
   parameter int WIN_W      = 22,
   parameter int HOLD_W     = 23
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LANES-1:0] note_arrive,
   input  logic [LANES-1:0] buttons,
   output logic [LANES-1:0] noteAction,
   output logic [LANES-1:0] noteSuccessState,
   output logic [15:0]      score,
   output logic [7:0]       combo
);

   localparam int CNT_W = $clog2(LANES + 1);

   logic [LANES-1:0] hit_vec, miss_vec;
   logic [CNT_W-1:0] hit_cnt;
   logic [16:0]      score_sum;
   logic [8:0]       combo_sum;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      note_lane_judge #(
         .WINDOW_CYC (WINDOW_CYC),
         .HOLD_CYC   (HOLD_CYC),
         .WIN_W      (WIN_W),
         .HOLD_W     (HOLD_W)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .note_arrive (note_arrive[i]),
         .button      (buttons[i]),
         .action      (noteAction[i]),
         .success     (noteSuccessState[i]),
         .hit         (hit_vec[i]),
         .miss        (miss_vec[i])
      );
   end

   always_comb begin
      hit_cnt = '0;
      for (int i = 0; i < LANES; i++)
         hit_cnt = hit_cnt + CNT_W'(hit_vec[i]);
   end

   // one extra bit of headroom so the carry out selects the clamp
   assign score_sum = {1'b0, score} + 17'(hit_cnt) * 17'(HIT_POINTS);
   assign combo_sum = {1'b0, combo} + 9'(hit_cnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         score <= '0;
         combo <= '0;
      end else begin
         score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
         if (|miss_vec)
            combo <= '0;
         else
            combo <= combo_sum[8] ? 8'hFF : combo_sum[7:0];
      end
   end

endmodule

// File: tb/tb_note_judge.sv
// tb/tb_note_judge.sv - directed vectors for note_judge with WINDOW_CYC=8, HOLD_CYC=4
module tb_note_judge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  note_arrive = '0;
   logic [7:0]  buttons = '0;
   logic [7:0]  noteAction, noteSuccessState;
   logic [15:0] score;
   logic [7:0]  combo;

   int vectors = 0;
   int miscompares = 0;

   note_judge #(
      .LANES      (8),
      .WINDOW_CYC (8),
      .HOLD_CYC   (4),
      .HIT_POINTS (10),
      .WIN_W      (4),
      .HOLD_W     (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .note_arrive      (note_arrive),
      .buttons          (buttons),
      .noteAction       (noteAction),
      .noteSuccessState (noteSuccessState),
      .score            (score),
      .combo            (combo)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // arrival, then a press landing 3 cycles into the window, then full settle
   task automatic hit_burst(input logic [7:0] mask);
      note_arrive = mask;
      step(1);
      note_arrive = '0;
      buttons = mask;
      step(4);
      buttons = '0;
      step(4);
   endtask

   initial begin
      step(2);
      check_eq("rst_action", noteAction, 8'h00);
      check_eq("rst_success", noteSuccessState, 8'h00);
      check_eq("rst_score", score, 16'd0);
      check_eq("rst_combo", combo, 8'd0);
      rst = 1'b0;

      // single hit, button raised two cycles after arrival
      note_arrive = 8'h01;
      step(1);
      note_arrive = '0;
      step(1);
      buttons = 8'h01;
      step(4);
      check_eq("hit_action", noteAction, 8'h01);
      check_eq("hit_success", noteSuccessState, 8'h01);
      check_eq("hit_score", score, 16'd10);
      check_eq("hit_combo", combo, 8'd1);
      step(3);
      check_eq("hit_hold_last", noteAction, 8'h01);
      step(1);
      check_eq("hit_hold_end_act", noteAction, 8'h00);
      check_eq("hit_hold_end_succ", noteSuccessState, 8'h00);
      check_eq("hit_held_btn_combo", combo, 8'd1);
      buttons = '0;
      step(4);

      hit_burst(8'h01);
      hit_burst(8'h01);
      check_eq("pre_miss_combo", combo, 8'd3);

      // miss on lane 2
      note_arrive = 8'h04;
      step(1);
      note_arrive = '0;
      step(7);
      check_eq("miss_before_expiry", noteAction, 8'h00);
      step(1);
      check_eq("miss_action", noteAction, 8'h04);
      check_eq("miss_success", noteSuccessState, 8'h00);
      check_eq("miss_combo", combo, 8'd0);
      check_eq("miss_score", score, 16'd30);
      step(3);
      check_eq("miss_hold_last", noteAction, 8'h04);
      step(1);
      check_eq("miss_hold_end", noteAction, 8'h00);

      // press exactly on the expiry cycle
      note_arrive = 8'h02;
      step(1);
      note_arrive = '0;
      step(4);
      buttons = 8'h02;
      step(4);
      check_eq("edge_hit_action", noteAction, 8'h02);
      check_eq("edge_hit_success", noteSuccessState, 8'h02);
      check_eq("edge_hit_combo", combo, 8'd1);
      check_eq("edge_hit_score", score, 16'd40);
      buttons = '0;
      step(5);

      // press one cycle after expiry
      note_arrive = 8'h02;
      step(1);
      note_arrive = '0;
      step(5);
      buttons = 8'h02;
      step(3);
      check_eq("late_action", noteAction, 8'h02);
      check_eq("late_success", noteSuccessState, 8'h00);
      check_eq("late_combo", combo, 8'd0);
      step(1);
      check_eq("late_ignored_succ", noteSuccessState, 8'h00);
      check_eq("late_ignored_score", score, 16'd40);
      step(4);
      check_eq("late_hold_end", noteAction, 8'h00);
      check_eq("late_idle_combo", combo, 8'd0);
      buttons = '0;
      step(4);

      hit_burst(8'h01);
      check_eq("pre_multi_combo", combo, 8'd1);

      // lanes 0,1,7 hit on expiry while lane 3 expires unpressed
      note_arrive = 8'h8B;
      step(1);
      note_arrive = '0;
      step(4);
      buttons = 8'h83;
      step(4);
      check_eq("multi_action", noteAction, 8'h8B);
      check_eq("multi_success", noteSuccessState, 8'h83);
      check_eq("multi_score", score, 16'd80);
      check_eq("multi_combo", combo, 8'd0);
      buttons = '0;
      step(5);

      // re-arrival on lane 2: miss, then hit restarting the hold
      note_arrive = 8'h04;
      step(1);
      note_arrive = '0;
      step(2);
      note_arrive = 8'h04;
      step(1);
      note_arrive = '0;
      check_eq("rearr_miss_action", noteAction, 8'h04);
      check_eq("rearr_miss_success", noteSuccessState, 8'h00);
      buttons = 8'h04;
      step(3);
      check_eq("rearr_miss_last", noteSuccessState, 8'h00);
      step(1);
      check_eq("rearr_hit_success", noteSuccessState, 8'h04);
      check_eq("rearr_score", score, 16'd90);
      check_eq("rearr_combo", combo, 8'd1);
      step(3);
      check_eq("rearr_restart_hold", noteAction, 8'h04);
      step(1);
      check_eq("rearr_hold_end", noteAction, 8'h00);
      buttons = '0;
      step(4);

      // asynchronous reset in the middle of a hold
      note_arrive = 8'h01;
      step(1);
      note_arrive = '0;
      buttons = 8'h01;
      step(5);
      check_eq("prereset_action", noteAction, 8'h01);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_rst_action", noteAction, 8'h00);
      check_eq("async_rst_success", noteSuccessState, 8'h00);
      check_eq("async_rst_score", score, 16'd0);
      check_eq("async_rst_combo", combo, 8'd0);
      buttons = '0;
      step(2);
      rst = 1'b0;

      // combo saturation: 31 bursts of 8 hits give 248, the 32nd clamps to 255
      for (int i = 0; i < 31; i++) hit_burst(8'hFF);
      check_eq("combo_248", combo, 8'd248);
      check_eq("score_2480", score, 16'd2480);
      hit_burst(8'hFF);
      check_eq("combo_sat", combo, 8'd255);
      check_eq("score_2560", score, 16'd2560);

      // score saturation: 819 bursts of 80 = 65520, +10 = FFFA, +10 clamps
      for (int i = 0; i < 787; i++) hit_burst(8'hFF);
      check_eq("score_fff0", score, 16'hFFF0);
      hit_burst(8'h01);
      check_eq("score_fffa", score, 16'hFFFA);
      hit_burst(8'h01);
      check_eq("score_sat", score, 16'hFFFF);
      hit_burst(8'hFF);
      check_eq("score_stays_sat", score, 16'hFFFF);
      check_eq("combo_stays_sat", combo, 8'd255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
